// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the datapath bus among four requesters, with lockable ownership and a registered bus-mux select.
// Define BUS_ARB_TIMEOUT_EN to force release of a locked owner after MAX_HOLD consecutive owned cycles.
module bus_arbiter #(
    parameter logic [4:0] PARK_SEL = 5'd20,
    parameter int         MAX_HOLD = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [19:0] sel_in,
    output logic [3:0]  gnt,
    output logic [4:0]  bus_sel,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_last;
    logic [7:0] r_hcnt;
    logic [3:0] r_gnt;
    logic [4:0] r_bus_sel;
    logic       r_busy;
    logic       r_timeout;

    logic [4:0] w_sel      [4];
    logic [1:0] w_order    [4];
    logic [3:0] w_cand;
    logic [3:0] w_cand_rot;
    logic [3:0] w_excl;
    logic       w_found;
    logic [1:0] w_win;
    logic [3:0] w_win_onehot;
    logic       w_hold;
    logic       w_tmo;

    // w_order[k] is the requester visited k-th in the search starting at last+1.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign w_sel[gi]      = sel_in[5*gi +: 5];
            assign w_order[gi]    = r_last + 2'(gi + 1);
            assign w_cand_rot[gi] = w_cand[w_order[gi]];
        end
    endgenerate

    // In OWN, r_last is the current owner, so its lock is the only one honoured.
    assign w_hold = (r_state == OWN) && req[r_last] && lock[r_last];

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    assign w_tmo  = w_hold && (r_hcnt == HOLD_LIMIT);
    assign w_excl = w_tmo ? (4'b0001 << r_last) : 4'b0000;
`else
    localparam int MAX_HOLD_UNUSED = MAX_HOLD;

    assign w_tmo  = 1'b0;
    assign w_excl = 4'b0000;
`endif

    assign w_cand = req & ~w_excl;

    always_comb begin
        w_found = |w_cand_rot;
        w_win   = w_order[3];
        if (w_cand_rot[0]) begin
            w_win = w_order[0];
        end else if (w_cand_rot[1]) begin
            w_win = w_order[1];
        end else if (w_cand_rot[2]) begin
            w_win = w_order[2];
        end
    end

    assign w_win_onehot = 4'b0001 << w_win;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state   <= IDLE;
            r_last    <= 2'd3;
            r_hcnt    <= 8'd0;
            r_gnt     <= 4'b0000;
            r_bus_sel <= PARK_SEL;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state   <= OWN;
                        r_gnt     <= w_win_onehot;
                        r_bus_sel <= w_sel[w_win];
                        r_last    <= w_win;
                        r_hcnt    <= 8'd1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_gnt     <= 4'b0000;
                        r_bus_sel <= PARK_SEL;
                        r_hcnt    <= 8'd0;
                        r_busy    <= 1'b0;
                    end
                end
                OWN: begin
                    if (w_hold && !w_tmo) begin
                        // Reload every cycle so a changing source code reaches the mux one cycle later.
                        r_bus_sel <= w_sel[r_last];
                        r_hcnt    <= (r_hcnt == 8'hFF) ? r_hcnt : r_hcnt + 8'd1;
                    end else if (w_found) begin
                        r_gnt     <= w_win_onehot;
                        r_bus_sel <= w_sel[w_win];
                        r_last    <= w_win;
                        r_hcnt    <= 8'd1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state   <= IDLE;
                        r_gnt     <= 4'b0000;
                        r_bus_sel <= PARK_SEL;
                        r_hcnt    <= 8'd0;
                        r_busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign bus_sel = r_bus_sel;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
